// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_ctrl                                              |
// | Description : MOV/MOC initiator toward the 256x32 data RAM. Runs single    |
// |               byte/half/word accesses and splits double words into two    |
// |               word beats. Byte and half loads are sign- or zero-extended.  |
// |               Define MEM_ACC_TIMEOUT_EN to abort a beat that waits         |
// |               TIMEOUT_CYCLES edges for MOC.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [63:0] wdata,
  input  logic [1:0]  dtype,
  input  logic        signed_ld,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [7:0]  Address,
  output logic [31:0] DataIn,
  output logic [1:0]  DataType,
  input  logic [31:0] DataOut,
  input  logic        MOC
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_GAP  = 3'd2,
    S_ACC2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Value the wait counter holds at the edge on which one more MOC=0 times out.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        mov_q, mov_d;
  logic        rw_q, rw_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [1:0]  dt_q, dt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] whi_q, whi_d;   // second-beat store data
  logic        sext_q, sext_d; // sign-extend byte/half loads
  logic [31:0] lo_q, lo_d;     // first-beat load data of a double word
  logic [31:0] w_ext;
  logic        w_tmo;

`ifdef MEM_ACC_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Count MOC=0 edges of the current beat; zero whenever no beat is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_ACC1 || state_q == S_ACC2) begin
      if (!MOC) cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign w_tmo = !MOC && (cnt_q == c_tmo_last);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^c_tmo_last;
  assign w_tmo        = 1'b0;
`endif

  // Extend the low byte/half of the RAM word according to the latched type.
  always_comb begin
    case (dt_q)
      2'b00:   w_ext = {{24{sext_q & DataOut[7]}}, DataOut[7:0]};
      2'b01:   w_ext = {{16{sext_q & DataOut[15]}}, DataOut[15:0]};
      default: w_ext = DataOut;
    endcase
  end

  // Next-state and next-output logic; every output is a register.
  always_comb begin
    state_d = state_q;
    mov_d   = mov_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dt_d    = dt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    whi_d   = whi_q;
    sext_d  = sext_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = rw;
          addr_d  = addr;
          din_d   = wdata[31:0];
          dt_d    = dtype;
          whi_d   = wdata[63:32];
          sext_d  = signed_ld;
          mov_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_ACC1;
        end
      end
      S_ACC1: begin
        if (MOC) begin
          mov_d = 1'b0;
          if (dt_q == 2'b11) begin
            // Address wraps 255 -> 0 naturally in 8 bits.
            addr_d  = addr_q + 8'd1;
            din_d   = whi_q;
            if (rw_q) lo_d = DataOut;
            state_d = S_GAP;
          end else begin
            if (rw_q) rdata_d = {32'h0, w_ext};
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (w_tmo) begin
          mov_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        // One MOV-low cycle so the RAM sees a fresh MOV edge for beat two.
        mov_d   = 1'b1;
        state_d = S_ACC2;
      end
      S_ACC2: begin
        if (MOC) begin
          mov_d = 1'b0;
          if (rw_q) rdata_d = {DataOut, lo_q};
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (w_tmo) begin
          mov_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mov_q   <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      dt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      whi_q   <= '0;
      sext_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mov_q   <= mov_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dt_q    <= dt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      whi_q   <= whi_d;
      sext_q  <= sext_d;
      lo_q    <= lo_d;
    end
  end

  assign MOV       = mov_q;
  assign ReadWrite = rw_q;
  assign Address   = addr_q;
  assign DataIn    = din_q;
  assign DataType  = dt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_ctrl                                           |
// | Description : Bench for mem_access_ctrl with a behavioural RAM slave and   |
// |               a word-array reference model of memory contents.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctrl;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset, req, rw, signed_ld, MOC;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  dtype;
  logic        busy, done, err, MOV, ReadWrite;
  logic [63:0] rdata;
  logic [7:0]  Address;
  logic [31:0] DataIn, DataOut;
  logic [1:0]  DataType;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] ram [256];
  bit          ram_load;
  int          cyc = 0;
  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];
  logic        log_rw [$];
  logic [1:0]  log_dt [$];
  int          log_cyc [$];
  logic [63:0] exp_rd;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .dtype(dtype), .signed_ld(signed_ld), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .MOV(MOV), .ReadWrite(ReadWrite), .Address(Address),
    .DataIn(DataIn), .DataType(DataType), .DataOut(DataOut), .MOC(MOC)
  );

  always #5 clk = ~clk;

  // RAM slave: read data is combinational, a beat completes at an edge with MOV & MOC.
  assign DataOut = ram[Address];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
    end else if (MOV && MOC && !reset) begin
      log_addr.push_back(Address);
      log_data.push_back(DataIn);
      log_rw.push_back(ReadWrite);
      log_dt.push_back(DataType);
      log_cyc.push_back(cyc);
      if (!ReadWrite) begin
        case (DataType)
          2'b00:   ram[Address][7:0]  <= DataIn[7:0];
          2'b01:   ram[Address][15:0] <= DataIn[15:0];
          default: ram[Address]       <= DataIn;
        endcase
      end
    end
  end

  // Reference load result computed arithmetically from the word array.
  function automatic logic [63:0] exp_load(logic [7:0] a, logic [1:0] dt, logic sg);
    logic [31:0] w, v;
    logic [7:0]  a2;
    w = ref_mem[a];
    v = w;
    case (dt)
      2'b00: begin v = w % 256;   if (sg && v >= 128)   v = v - 256;   end
      2'b01: begin v = w % 65536; if (sg && v >= 32768) v = v - 65536; end
      2'b10: v = w;
      default: begin a2 = a + 8'd1; return {ref_mem[a2], w}; end
    endcase
    return {32'h0, v};
  endfunction

  function automatic void ref_store(logic [7:0] a, logic [1:0] dt, logic [63:0] wd);
    logic [7:0] a2;
    a2 = a + 8'd1;
    case (dt)
      2'b00: ref_mem[a] = (ref_mem[a] & 32'hFFFF_FF00) | (wd[31:0] & 32'h0000_00FF);
      2'b01: ref_mem[a] = (ref_mem[a] & 32'hFFFF_0000) | (wd[31:0] & 32'h0000_FFFF);
      2'b10: ref_mem[a] = wd[31:0];
      default: begin ref_mem[a] = wd[31:0]; ref_mem[a2] = wd[63:32]; end
    endcase
  endfunction

  // Issue one request from IDLE and follow it to done (bounded).
  // o_lat counts falling edges after acceptance up to the one that sees done.
  task automatic run_txn(input logic i_rw, input logic [7:0] i_a, input logic [63:0] i_wd,
                         input logic [1:0] i_dt, input logic i_sg, input int stall_fix,
                         input bit rnd_stall, output logic [63:0] o_rd, output logic o_err,
                         output int o_lat, output int o_zeros, output bit o_to);
    int left;
    @(negedge clk);
    rw = i_rw; addr = i_a; wdata = i_wd; dtype = i_dt; signed_ld = i_sg; req = 1'b1; MOC = 1'b1;
    @(posedge clk);
    left = stall_fix; o_lat = 0; o_zeros = 0; o_to = 1'b1; o_rd = '0; o_err = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      req = 1'b0;
      o_lat++;
      if (done) begin o_to = 1'b0; o_rd = rdata; o_err = err; break; end
      if (MOV && left > 0) begin MOC = 1'b0; left--; o_zeros++; end
      else if (MOV && rnd_stall && $urandom_range(3) == 0) begin MOC = 1'b0; o_zeros++; end
      else MOC = 1'b1;
    end
    MOC = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; dtype = '0;
    signed_ld = 1'b0; MOC = 1'b1; ram_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({MOV, ReadWrite, Address, DataIn, DataType} !== {1'b0, 1'b1, 8'h00, 32'h0, 2'b00}) begin
      n_err++; $display("FAIL reset_ram_if: got %h expected %h",
        {MOV, ReadWrite, Address, DataIn, DataType}, {1'b0, 1'b1, 8'h00, 32'h0, 2'b00});
    end
    n_vec++;
    if ({busy, done, err} !== 3'b000) begin
      n_err++; $display("FAIL reset_status: got %b expected 000", {busy, done, err});
    end
    n_vec++;
    if (rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b0; ram_load = 1'b0;
    exp_rd = '0;
  endtask

  task automatic test_word_wr_rd();
    logic [63:0] rd; logic e; int lat, z; bit to;
    run_txn(1'b0, 8'h10, 64'h0000_0000_1234_5678, 2'b10, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    ref_store(8'h10, 2'b10, 64'h1234_5678);
    n_vec++;
    if (to || lat !== 2 || e !== 1'b0 || rd !== exp_rd) begin
      n_err++; $display("FAIL word_write: to=%0d lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=%h",
                        to, lat, e, rd, exp_rd);
    end
    run_txn(1'b1, 8'h10, 64'h0, 2'b10, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    exp_rd = 64'h0000_0000_1234_5678;
    n_vec++;
    if (to || lat !== 2 || e !== 1'b0 || rd !== exp_rd) begin
      n_err++; $display("FAIL word_read: to=%0d lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=%h",
                        to, lat, e, rd, exp_rd);
    end
  endtask

  task automatic test_signed_byte();
    logic [63:0] rd; logic e; int lat, z; bit to;
    run_txn(1'b0, 8'h20, 64'h0000_00F0, 2'b10, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    ref_store(8'h20, 2'b10, 64'h0000_00F0);
    run_txn(1'b1, 8'h20, 64'h0, 2'b00, 1'b1, 0, 1'b0, rd, e, lat, z, to);
    n_vec++;
    if (to || rd !== 64'h0000_0000_FFFF_FFF0) begin
      n_err++; $display("FAIL byte_signed: to=%0d rdata=%h expected 00000000fffffff0", to, rd);
    end
    run_txn(1'b1, 8'h20, 64'h0, 2'b00, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    exp_rd = 64'h0000_0000_0000_00F0;
    n_vec++;
    if (to || rd !== exp_rd) begin
      n_err++; $display("FAIL byte_unsigned: to=%0d rdata=%h expected %h", to, rd, exp_rd);
    end
  endtask

  task automatic test_dword_wrap();
    logic [63:0] rd; logic e; int lat, z, n0; bit to;
    n0 = log_addr.size();
    run_txn(1'b0, 8'hFF, 64'hAAAA_0001_BBBB_0002, 2'b11, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    ref_store(8'hFF, 2'b11, 64'hAAAA_0001_BBBB_0002);
    n_vec++;
    if (to || lat !== 4 || log_addr.size() - n0 !== 2) begin
      n_err++; $display("FAIL dword_write: to=%0d lat=%0d beats=%0d expected lat=4 beats=2",
                        to, lat, log_addr.size() - n0);
    end else begin
      n_vec++;
      if (log_addr[n0] !== 8'hFF || log_addr[n0+1] !== 8'h00 ||
          log_data[n0] !== 32'hBBBB_0002 || log_data[n0+1] !== 32'hAAAA_0001) begin
        n_err++; $display("FAIL dword_beats: addr %h/%h data %h/%h expected ff/00 bbbb0002/aaaa0001",
                          log_addr[n0], log_addr[n0+1], log_data[n0], log_data[n0+1]);
      end
      n_vec++;
      if (log_cyc[n0+1] - log_cyc[n0] !== 2) begin
        n_err++; $display("FAIL dword_gap: beat spacing %0d expected 2", log_cyc[n0+1] - log_cyc[n0]);
      end
    end
    run_txn(1'b1, 8'hFF, 64'h0, 2'b11, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    exp_rd = 64'hAAAA_0001_BBBB_0002;
    n_vec++;
    if (to || lat !== 4 || rd !== exp_rd) begin
      n_err++; $display("FAIL dword_read: to=%0d lat=%0d rdata=%h expected lat=4 rdata=%h", to, lat, rd, exp_rd);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rd; logic e; int lat, z; bit to;
    run_txn(1'b1, 8'h10, 64'h0, 2'b10, 1'b0, 3, 1'b0, rd, e, lat, z, to);
    exp_rd = 64'h0000_0000_1234_5678;
    n_vec++;
    if (to || lat !== 5 || rd !== exp_rd || e !== 1'b0) begin
      n_err++; $display("FAIL stall_read: to=%0d lat=%0d err=%b rdata=%h expected lat=5 err=0 rdata=%h",
                        to, lat, e, rd, exp_rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic e; int lat, z, nd; bit to;
    @(negedge clk);
    rw = 1'b1; addr = 8'h40; dtype = 2'b11; signed_ld = 1'b0; req = 1'b1; MOC = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (MOV !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_acc2: MOV=%b busy=%b expected 1 1", MOV, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({MOV, busy, done, rdata} !== {3'b000, 64'h0}) begin
      n_err++; $display("FAIL midrst_state: MOV=%b busy=%b done=%b rdata=%h expected 0 0 0 0",
                        MOV, busy, done, rdata);
    end
    @(negedge clk); reset = 1'b0;
    exp_rd = '0;
    nd = 0;
    repeat (4) begin @(negedge clk); if (done) nd++; end
    n_vec++;
    if (nd !== 0) begin n_err++; $display("FAIL midrst_no_done: done pulses %0d expected 0", nd); end
    run_txn(1'b1, 8'h10, 64'h0, 2'b10, 1'b0, 0, 1'b0, rd, e, lat, z, to);
    exp_rd = exp_load(8'h10, 2'b10, 1'b0);
    n_vec++;
    if (to || lat !== 2 || rd !== exp_rd) begin
      n_err++; $display("FAIL midrst_recover: to=%0d lat=%0d rdata=%h expected lat=2 rdata=%h", to, lat, rd, exp_rd);
    end
  endtask

  task automatic test_req_held();
    int n0, k;
    @(negedge clk);
    rw = 1'b1; addr = 8'h10; dtype = 2'b10; signed_ld = 1'b0; req = 1'b1; MOC = 1'b1;
    @(posedge clk);
    n0 = log_addr.size();
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 20);
    n_vec++;
    if (!done || busy !== 1'b1 || log_addr.size() - n0 !== 1) begin
      n_err++; $display("FAIL held_first: done=%b busy=%b beats=%0d expected 1 1 1", done, busy, log_addr.size() - n0);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || log_addr.size() - n0 !== 1) begin
      n_err++; $display("FAIL held_idle: busy=%b beats=%0d expected 0 1", busy, log_addr.size() - n0);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL held_second_accept: busy=%b expected 1", busy); end
    req = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 20);
    n_vec++;
    if (!done || log_addr.size() - n0 !== 2) begin
      n_err++; $display("FAIL held_second_done: done=%b beats=%0d expected 1 2", done, log_addr.size() - n0);
    end
    exp_rd = exp_load(8'h10, 2'b10, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] rd, wd; logic e, r, sg; logic [7:0] a; logic [1:0] dt; int lat, z, n0, nb; bit to;
    for (int it = 0; it < 60; it++) begin
      r  = 1'($urandom_range(1));
      a  = 8'($urandom);
      if (it % 8 == 0) a = 8'hFF;
      wd = {$urandom, $urandom};
      dt = 2'($urandom_range(3));
      sg = 1'($urandom_range(1));
      nb = (dt == 2'b11) ? 2 : 1;
      n0 = log_addr.size();
      run_txn(r, a, wd, dt, sg, 0, 1'b1, rd, e, lat, z, to);
      if (r) exp_rd = exp_load(a, dt, sg);
      else   ref_store(a, dt, wd);
      n_vec++;
      if (to || lat !== 2 * nb + z || e !== 1'b0 || rd !== exp_rd) begin
        n_err++; $display("FAIL rand_txn %0d: rw=%b a=%h dt=%b to=%0d lat=%0d err=%b rdata=%h expected lat=%0d err=0 rdata=%h",
                          it, r, a, dt, to, lat, e, rd, 2 * nb + z, exp_rd);
      end
      n_vec++;
      if (log_addr.size() - n0 !== nb || log_addr[n0] !== a || log_rw[n0] !== r ||
          log_dt[n0] !== dt || (!r && log_data[n0] !== wd[31:0])) begin
        n_err++; $display("FAIL rand_beat %0d: beats=%0d addr=%h rw=%b dt=%b data=%h expected %0d %h %b %b %h",
                          it, log_addr.size() - n0, log_addr[n0], log_rw[n0], log_dt[n0], log_data[n0],
                          nb, a, r, dt, wd[31:0]);
      end
    end
  endtask

`ifdef MEM_ACC_TIMEOUT_EN
  // MOC held low from ACC1 entry: done/err land TMO edges after acceptance,
  // which is the (TMO+1)-th falling edge in the run_txn count.
  task automatic test_timeout();
    logic [63:0] rd; logic e; int lat, z; bit to;
    run_txn(1'b1, 8'h10, 64'h0, 2'b10, 1'b0, 1000, 1'b0, rd, e, lat, z, to);
    n_vec++;
    if (to || lat !== TMO + 1 || e !== 1'b1 || rd !== exp_rd) begin
      n_err++; $display("FAIL timeout: to=%0d lat=%0d err=%b rdata=%h expected lat=%0d err=1 rdata=%h",
                        to, lat, e, rd, TMO + 1, exp_rd);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    test_reset();
    test_word_wr_rd();
    test_signed_byte();
    test_dword_wrap();
    test_stall();
    test_reset_mid();
    test_req_held();
    test_random();
`ifdef MEM_ACC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
